// File: rtl/post_code_uart_pkg.sv
// Shared constants, state encodings and helpers for the POST-code UART sink.
// Character generation and the bit-period calculation live here.
`ifndef CLOCK_SPEED
`define CLOCK_SPEED 50000000
`endif

package post_code_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_SEND
    } seq_state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_A_M10 = 8'h37;

    // Rounded clocks per bit.
    function automatic int calc_div(input int clk_in, input int baud);
        return (clk_in + baud / 2) / baud;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return ASCII_ZERO + {4'h0, n};
        return ASCII_A_M10 + {4'h0, n};
    endfunction

    function automatic logic [7:0] code_char(
        input logic [7:0] code,
        input logic [1:0] idx
    );
        logic [7:0] c;
        unique case (idx)
            2'd0:    c = hex_char(code[7:4]);
            2'd1:    c = hex_char(code[3:0]);
            2'd2:    c = ASCII_CR;
            default: c = ASCII_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer; a new byte may be started on the last stop-bit cycle,
// so consecutive frames follow each other with no gap.
module uart_tx_byte
    import post_code_uart_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic [7:0] iData,
    output logic       oTx,
    output logic       oBusy,
    output logic       oDone
);

    localparam int CW = $clog2(DIV);

    tx_state_t   state;
    logic [CW-1:0] baud;
    logic [7:0]  shift;
    logic [2:0]  bit_idx;
    logic        tick;

    assign tick  = (baud == CW'(DIV - 1));
    assign oBusy = (state != TX_IDLE);
    assign oDone = (state == TX_STOP) && tick;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= TX_IDLE;
            baud    <= '0;
            shift   <= '0;
            bit_idx <= '0;
            oTx     <= 1'b1;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    if (iStart) begin
                        state <= TX_START;
                        shift <= iData;
                        baud  <= '0;
                        oTx   <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= TX_DATA;
                        oTx     <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            oTx   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= {1'b0, shift[7:1]};
                            oTx     <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        baud <= '0;
                        if (iStart) begin
                            state <= TX_START;
                            shift <= iData;
                            oTx   <= 1'b0;
                        end else begin
                            state <= TX_IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/post_code_uart.sv
// Captures I/O writes to the POST port into a FIFO and streams each code
// as two hex digits plus CR LF on the serial pin.
module post_code_uart
    import post_code_uart_pkg::*;
#(
    parameter int          CLK_IN     = `CLOCK_SPEED,
    parameter int          BAUD       = 115200,
    parameter logic [15:0] PORT       = 16'h0080,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [19:0] iAddr,
    input  logic        iWr,
    input  logic [7:0]  iWrData,
    input  logic        iRd,
    output logic [7:0]  oRdData,
    output logic        oSel,
    output logic        oTx,
    output logic        oOverflow
);

    localparam int DIV = calc_div(CLK_IN, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    last_code;
    logic [7:0]    code;
    logic [1:0]    char_idx;
    seq_state_t    seq;
    logic          overflow;

    logic       hit;
    logic       wr_hit;
    logic       pop;
    logic       push;
    logic       tx_start;
    logic       tx_done;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       unused_bits;

    assign hit    = (iAddr[15:0] == PORT);
    assign wr_hit = iWr & hit;
    assign pop    = (seq == SEQ_IDLE) && (count != '0);
    // A full FIFO still takes the write when the head leaves on this edge.
    assign push   = wr_hit &&
                    ((count < (AW + 1)'(FIFO_DEPTH)) || pop);

    assign tx_start = pop | (tx_done && (char_idx != 2'd3));
    assign tx_data  = pop ? hex_char(mem[rd_ptr][7:4])
                          : code_char(code, char_idx + 2'd1);

    assign oSel      = iRd & hit;
    assign oRdData   = last_code;
    assign oOverflow = overflow;

    assign unused_bits = ^{iAddr[19:16], tx_busy};

    always_ff @(posedge iClk) begin
        if (push)
            mem[wr_ptr] <= iWrData;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_code <= 8'h00;
            code      <= 8'h00;
            char_idx  <= 2'd0;
            seq       <= SEQ_IDLE;
            overflow  <= 1'b0;
        end else begin
            if (wr_hit)
                last_code <= iWrData;
            if (wr_hit && !push)
                overflow <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            unique case (seq)
                SEQ_IDLE: begin
                    if (pop) begin
                        code     <= mem[rd_ptr];
                        char_idx <= 2'd0;
                        seq      <= SEQ_SEND;
                    end
                end
                SEQ_SEND: begin
                    if (tx_done) begin
                        if (char_idx == 2'd3)
                            seq <= SEQ_IDLE;
                        else
                            char_idx <= char_idx + 2'd1;
                    end
                end
                default: seq <= SEQ_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (tx_start),
        .iData  (tx_data),
        .oTx    (oTx),
        .oBusy  (tx_busy),
        .oDone  (tx_done)
    );

endmodule

// File: tb/tb_post_code_uart.sv
// Bench for post_code_uart: serial receiver model decodes the line and
// compares against codes predicted from the bus writes.
module tb_post_code_uart;

    localparam int DIV   = 16;
    localparam int DEPTH = 16;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [19:0] iAddr;
    logic        iWr;
    logic [7:0]  iWrData;
    logic        iRd;
    logic [7:0]  oRdData;
    logic        oSel;
    logic        oTx;
    logic        oOverflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    logic [8:0] rx_q[$];
    int         rx_cyc[$];
    logic [8:0] exp_q[$];

    post_code_uart #(
        .CLK_IN     (1600),
        .BAUD       (100),
        .PORT       (16'h0080),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iAddr     (iAddr),
        .iWr       (iWr),
        .iWrData   (iWrData),
        .iRd       (iRd),
        .oRdData   (oRdData),
        .oSel      (oSel),
        .oTx       (oTx),
        .oOverflow (oOverflow)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    function automatic logic [7:0] asc_hex(input int n);
        if (n < 10)
            return 8'(48 + n);
        return 8'(65 + n - 10);
    endfunction

    task automatic expect_code(input logic [7:0] c);
        exp_q.push_back({1'b1, asc_hex(int'(c) / 16)});
        exp_q.push_back({1'b1, asc_hex(int'(c) % 16)});
        exp_q.push_back(9'h10D);
        exp_q.push_back(9'h10A);
    endtask

    task automatic bus_wr(input logic [19:0] a, input logic [7:0] d);
        iAddr   = a;
        iWrData = d;
        iWr     = 1'b1;
        tick(1);
        iWr     = 1'b0;
    endtask

    task automatic bus_rd(input logic [19:0] a,
                          output logic sel,
                          output logic [7:0] d);
        iAddr = a;
        iRd   = 1'b1;
        #1;
        sel   = oSel;
        d     = oRdData;
        iRd   = 1'b0;
    endtask

    task automatic wait_chars(input int n, input int budget,
                              input string tag);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, rx_q.size(), n);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size())
                check(tag, rx_q[i], exp_q[i]);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_cyc.delete();
        exp_q.delete();
    endtask

    // Burst of writes into an idle, empty FIFO: one code leaves at once,
    // the next DEPTH are queued and any further ones are dropped.
    task automatic burst(input int n, input string tag);
        logic [7:0] c;
        logic [7:0] last;
        logic       sel;
        logic [7:0] rd;
        last = 8'h00;
        for (int i = 0; i < n; i++) begin
            c = 8'($urandom_range(0, 255));
            bus_wr(20'h00080, c);
            if (i <= DEPTH)
                expect_code(c);
            last = c;
        end
        wait_chars(exp_q.size(), exp_q.size() * 10 * DIV + 200, tag);
        compare_rx(tag);
        check({tag, "_ovf"}, oOverflow, (n > DEPTH + 1));
        bus_rd(20'h00080, sel, rd);
        check({tag, "_readback"}, rd, last);
        clear_rx();
        tick(DIV);
    endtask

    initial begin : monitor
        int         s;
        logic [7:0] d;
        logic       ok;
        forever begin
            tick(1);
            if (mon_en && oTx === 1'b0) begin
                s = cyc;
                tick(DIV / 2);
                ok = (oTx === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    tick(DIV);
                    d[i] = oTx;
                end
                tick(DIV);
                rx_q.push_back({ok & (oTx === 1'b1), d});
                rx_cyc.push_back(s);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         w;
        int         lows;
        logic       sel;
        logic [7:0] rd;
        logic [7:0] c;

        iRst    = 1'b1;
        iWr     = 1'b0;
        iRd     = 1'b0;
        iAddr   = '0;
        iWrData = '0;
        tick(3);
        check("reset_tx", oTx, 1'b1);
        check("reset_ovf", oOverflow, 1'b0);
        check("reset_rddata", oRdData, 8'h00);
        iRst = 1'b0;
        mon_en = 1'b1;

        lows = 0;
        repeat (100) begin
            tick(1);
            if (oTx !== 1'b1)
                lows++;
        end
        check("idle_tx_low", lows, 0);
        check("idle_ovf", oOverflow, 1'b0);
        bus_rd(20'h00080, sel, rd);
        check("idle_sel", sel, 1'b1);
        check("idle_rddata", rd, 8'h00);

        bus_wr(20'h00080, 8'hA5);
        w = cyc;
        check("a5_tx_at_write", oTx, 1'b1);
        tick(1);
        check("a5_tx_fall", oTx, 1'b0);
        expect_code(8'hA5);
        wait_chars(4, 50 * DIV, "a5_wait");
        compare_rx("a5_chars");
        if (rx_cyc.size() >= 4) begin
            check("a5_first_start", rx_cyc[0], w + 1);
            check("a5_last_start", rx_cyc[3] - rx_cyc[0], 30 * DIV);
        end
        while (cyc < w + 1 + 40 * DIV + 20)
            tick(1);
        check("a5_end_tx", oTx, 1'b1);
        check("a5_no_extra", rx_q.size(), 4);
        clear_rx();

        bus_wr(20'h00080, 8'h09);
        w = cyc;
        bus_wr(20'h00080, 8'h3C);
        expect_code(8'h09);
        expect_code(8'h3C);
        wait_chars(8, 90 * DIV, "pair_wait");
        compare_rx("pair_chars");
        if (rx_cyc.size() >= 8) begin
            check("pair_start", rx_cyc[0], w + 1);
            check("pair_gap", rx_cyc[4] - rx_cyc[3], 10 * DIV + 1);
        end
        bus_rd(20'h00080, sel, rd);
        check("pair_readback", rd, 8'h3C);
        clear_rx();
        tick(DIV);

        burst(DEPTH + 1, "burst17");
        burst(DEPTH + 2, "burst18");

        bus_rd(20'h00080, sel, rd);
        c = rd;
        bus_wr(20'h00081, 8'h5A);
        iAddr   = 20'h00080;
        iWrData = 8'h77;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            w = int'($urandom_range(0, 16'hFFFF));
            if (w[15:0] == 16'h0080)
                w = 16'h1234;
            bus_wr(20'(w), 8'($urandom_range(0, 255)));
        end
        lows = 0;
        repeat (40 * DIV) begin
            tick(1);
            if (oTx !== 1'b1)
                lows++;
        end
        check("other_tx_low", lows, 0);
        check("other_rx", rx_q.size(), 0);
        bus_rd(20'h00081, sel, rd);
        check("other_sel", sel, 1'b0);
        bus_rd(20'h00080, sel, rd);
        check("other_readback", rd, c);
        check("other_ovf_sticky", oOverflow, 1'b1);

        mon_en = 1'b0;
        tick(DIV);
        bus_wr(20'h00080, 8'($urandom_range(0, 255)));
        w = cyc;
        bus_wr(20'h00080, 8'($urandom_range(0, 255)));
        bus_wr(20'h00080, 8'($urandom_range(0, 255)));
        while (cyc < w + 1 + 11 * DIV + 3 * DIV + 5)
            tick(1);
        iRst = 1'b1;
        tick(1);
        check("rst_mid_tx", oTx, 1'b1);
        check("rst_mid_ovf", oOverflow, 1'b0);
        tick(1);
        iRst = 1'b0;
        lows = 0;
        repeat (50 * DIV) begin
            tick(1);
            if (oTx !== 1'b1)
                lows++;
        end
        check("rst_no_output", lows, 0);
        bus_rd(20'h00080, sel, rd);
        check("rst_readback", rd, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
